// File: rtl/ins_queue.sv
// Fetch-to-decode instruction queue: splits fetch words into 16-bit entries, optional lui-r7 prefix fusion.
// Latency 1 cycle fetch->out (no bypass); fetch_ready from registered count only, out_valid/out_ready handshake.
module ins_queue #(
   parameter int FW    = 16,
   parameter int DEPTH = 4,
   parameter int AW    = 24,
   parameter int FUSE  = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          fetch_valid,
   output logic          fetch_ready,
   input  logic [FW-1:0] fetch_data,
   input  logic [AW-1:0] fetch_pc,
   input  logic          fetch_fault,
   input  logic          flush,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [15:0]   out_ins,
   output logic [AW-1:0] out_pc,
   output logic          out_fault,
   output logic          out_pfx_valid,
   output logic [15:0]   out_pfx
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
   localparam logic [PW:0] NPF_C   = (PW+1)'(FW/16);
   localparam logic [PW:0] ONE_C   = (PW+1)'(1);
   localparam logic [PW:0] TWO_C   = (PW+1)'(2);

   logic [15:0]   ins_mem [DEPTH];
   logic [AW-1:0] pc_mem  [DEPTH];
   logic          flt_mem [DEPTH];

   logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt;
   logic [PW:0]   count, np, nq;
   logic [15:0]   lo_half, hi_half, wdat0;
   logic [AW-1:0] wpc1;
   logic          two_push, odd_start, push, pop;
   logic [15:0]   h_ins, s_ins;
   logic          h_flt, s_flt, h_pfx, fuse_now, pfx_wait;

   // For FW=16 both halves alias the single instruction slot.
   assign lo_half   = fetch_data[15:0];
   assign hi_half   = fetch_data[FW-1 -: 16];
   assign two_push  = (FW == 32) && !fetch_pc[1];
   assign odd_start = (FW == 32) && fetch_pc[1];
   assign wdat0     = odd_start ? hi_half : lo_half;
   assign wpc1      = fetch_pc + AW'(2);
   assign np        = two_push ? TWO_C : ONE_C;

   assign rd_nxt = rd_ptr + PW'(1);
   assign wr_nxt = wr_ptr + PW'(1);

   assign h_ins = ins_mem[rd_ptr];
   assign h_flt = flt_mem[rd_ptr];
   assign s_ins = ins_mem[rd_nxt];
   assign s_flt = flt_mem[rd_nxt];

   // lui targeting r7: opcode 01011, rd 111, immediate-select bit clear.
   assign h_pfx    = (FUSE != 0) && (h_ins[15:7] == 9'b0101_1111_0);
   assign fuse_now = h_pfx && (count >= TWO_C) && !h_flt && !s_flt;
   assign pfx_wait = h_pfx && !h_flt && (count == ONE_C);
   assign nq       = fuse_now ? TWO_C : ONE_C;

   assign fetch_ready   = (DEPTH_C - count) >= NPF_C;
   assign out_valid     = (count != '0) && !pfx_wait;
   assign out_ins       = fuse_now ? s_ins : h_ins;
   assign out_pc        = fuse_now ? pc_mem[rd_nxt] : pc_mem[rd_ptr];
   assign out_fault     = fuse_now ? s_flt : h_flt;
   assign out_pfx_valid = fuse_now;
   assign out_pfx       = h_ins;

   assign push = fetch_valid && fetch_ready && !flush;
   assign pop  = out_valid && out_ready && !flush;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         count <= count + (push ? np : '0) - (pop ? nq : '0);
         if (pop)
            rd_ptr <= rd_ptr + nq[PW-1:0];
         if (push)
            wr_ptr <= wr_ptr + np[PW-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         ins_mem[wr_ptr] <= wdat0;
         pc_mem[wr_ptr]  <= fetch_pc;
         flt_mem[wr_ptr] <= fetch_fault;
         if (two_push) begin
            ins_mem[wr_nxt] <= hi_half;
            pc_mem[wr_nxt]  <= wpc1;
            flt_mem[wr_nxt] <= fetch_fault;
         end
      end
   end

endmodule

// File: tb/tb_ins_queue.sv
// Bench for ins_queue: instance a is FW=32/FUSE=1, instance b is FW=16/FUSE=0, both DEPTH=4.
module tb_ins_queue;

   typedef struct packed {
      logic [15:0] ins;
      logic [23:0] pc;
      logic        f;
   } ent_t;

   typedef struct packed {
      logic [15:0] ins;
      logic [23:0] pc;
      logic        f;
      logic        pv;
      logic [15:0] pfx;
   } xfer_t;

   bit clk;
   logic reset;

   logic        a_fv, a_rdy, a_ff, a_fl, a_ov, a_ordy, a_of, a_opv;
   logic [31:0] a_fd;
   logic [23:0] a_pc, a_opc;
   logic [15:0] a_oins, a_opfx;

   logic        b_fv, b_rdy, b_ff, b_fl, b_ov, b_ordy, b_of, b_opv;
   logic [15:0] b_fd;
   logic [23:0] b_pc, b_opc;
   logic [15:0] b_oins, b_opfx;

   int checks = 0;
   int errors = 0;

   ent_t  mq [2][8];
   int    msz [2];
   xfer_t loga[$];
   xfer_t logb[$];

   ins_queue #(.FW(32), .DEPTH(4), .AW(24), .FUSE(1)) dut_a (
      .clk(clk), .reset(reset),
      .fetch_valid(a_fv), .fetch_ready(a_rdy), .fetch_data(a_fd), .fetch_pc(a_pc),
      .fetch_fault(a_ff), .flush(a_fl),
      .out_valid(a_ov), .out_ready(a_ordy), .out_ins(a_oins), .out_pc(a_opc),
      .out_fault(a_of), .out_pfx_valid(a_opv), .out_pfx(a_opfx));

   ins_queue #(.FW(16), .DEPTH(4), .AW(24), .FUSE(0)) dut_b (
      .clk(clk), .reset(reset),
      .fetch_valid(b_fv), .fetch_ready(b_rdy), .fetch_data(b_fd), .fetch_pc(b_pc),
      .fetch_fault(b_ff), .flush(b_fl),
      .out_valid(b_ov), .out_ready(b_ordy), .out_ins(b_oins), .out_pc(b_opc),
      .out_fault(b_of), .out_pfx_valid(b_opv), .out_pfx(b_opfx));

   initial forever #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic lchk(input string nm, input int d, input int i, input xfer_t e);
      xfer_t a;
      int n;
      n = (d == 0) ? loga.size() : logb.size();
      checks++;
      if (i >= n) begin
         errors++;
         $display("FAIL %s: transfer %0d missing, only %0d seen", nm, i, n);
      end else begin
         a = (d == 0) ? loga[i] : logb[i];
         if (a !== e) begin
            errors++;
            $display("FAIL %s: got ins=%h pc=%h f=%b pv=%b pfx=%h, required ins=%h pc=%h f=%b pv=%b pfx=%h",
                     nm, a.ins, a.pc, a.f, a.pv, a.pfx, e.ins, e.pc, e.f, e.pv, e.pfx);
         end
      end
   endtask

   function automatic bit is_pfx(input logic [15:0] x);
      return x[15:11] == 5'b01011 && x[10:8] == 3'b111 && !x[7];
   endfunction

   // Queue-level reference: compare this cycle's outputs, then apply this cycle's handshakes.
   task automatic model(input int d, input int fw, input bit fuse,
                        input logic v, input logic r, input logic [15:0] ins, input logic [23:0] pc,
                        input logic f, input logic pv, input logic [15:0] pfx,
                        input logic fv, input logic [31:0] fd, input logic [23:0] fpc,
                        input logic ff, input logic fl, input logic ordy);
      int sz;
      ent_t h, s, o;
      bit e_fuse, e_wait, e_v, e_r;
      string p;
      xfer_t x;
      int n;
      p  = (d == 0) ? "a" : "b";
      sz = msz[d];
      h  = mq[d][0];
      s  = mq[d][1];
      e_fuse = fuse && sz >= 2 && is_pfx(h.ins) && !h.f && !s.f;
      e_wait = fuse && sz == 1 && is_pfx(h.ins) && !h.f;
      e_v    = sz >= 1 && !e_wait;
      e_r    = (4 - sz) >= fw / 16;
      chk({p, "_out_valid"}, v, e_v);
      chk({p, "_fetch_ready"}, r, e_r);
      if (e_v) begin
         o = e_fuse ? s : h;
         chk({p, "_out_ins"}, ins, o.ins);
         chk({p, "_out_pc"}, pc, o.pc);
         chk({p, "_out_fault"}, f, o.f);
         chk({p, "_out_pfx_valid"}, pv, e_fuse);
         if (e_fuse) chk({p, "_out_pfx"}, pfx, h.ins);
      end
      if (v && ordy && !fl && !reset) begin
         x = '{ins: ins, pc: pc, f: f, pv: pv, pfx: pv ? pfx : 16'h0};
         if (d == 0) loga.push_back(x); else logb.push_back(x);
      end
      if (reset || fl) begin
         msz[d] = 0;
      end else begin
         if (e_v && ordy) begin
            n = e_fuse ? 2 : 1;
            for (int k = 0; k < sz - n; k++) mq[d][k] = mq[d][k + n];
            sz = sz - n;
         end
         if (fv && e_r) begin
            if (fw == 32 && !fpc[1]) begin
               mq[d][sz]     = '{ins: fd[15:0],  pc: fpc,       f: ff};
               mq[d][sz + 1] = '{ins: fd[31:16], pc: fpc + 2,   f: ff};
               sz = sz + 2;
            end else begin
               mq[d][sz] = '{ins: (fw == 32) ? fd[31:16] : fd[15:0], pc: fpc, f: ff};
               sz = sz + 1;
            end
         end
         msz[d] = sz;
      end
   endtask

   always @(negedge clk) begin
      model(0, 32, 1'b1, a_ov, a_rdy, a_oins, a_opc, a_of, a_opv, a_opfx,
            a_fv, a_fd, a_pc, a_ff, a_fl, a_ordy);
      model(1, 16, 1'b0, b_ov, b_rdy, b_oins, b_opc, b_of, b_opv, b_opfx,
            b_fv, {16'h0, b_fd}, b_pc, b_ff, b_fl, b_ordy);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] rnd16();
      logic [31:0] r;
      r = $urandom;
      if (r[1:0] == 2'b00) return {9'b0101_1111_0, r[8:2]};
      return r[31:16];
   endfunction

   initial begin
      int pushed;
      logic [23:0] pcw;
      bit acc;
      msz[0] = 0; msz[1] = 0;
      reset = 1;
      a_fv = 0; a_fd = 0; a_pc = 0; a_ff = 0; a_fl = 0; a_ordy = 0;
      b_fv = 0; b_fd = 0; b_pc = 0; b_ff = 0; b_fl = 0; b_ordy = 0;
      repeat (3) step();
      chk("reset_a_valid", a_ov, 0);
      chk("reset_a_ready", a_rdy, 1);
      chk("reset_a_pfx_valid", a_opv, 0);
      chk("reset_b_valid", b_ov, 0);
      reset = 0;
      step();

      // FW=16 fill to full, then drain in order
      logb.delete();
      for (int i = 0; i < 4; i++) begin
         b_fv = 1; b_fd = 16'h4A11 + 16'(i); b_pc = 24'h100 + 24'(2 * i);
         step();
      end
      b_fv = 0;
      chk("t1_full_ready", b_rdy, 0);
      b_ordy = 1;
      step();
      chk("t1_ready_after_pop", b_rdy, 1);
      repeat (4) step();
      chk("t1_count", logb.size(), 4);
      for (int i = 0; i < 4; i++)
         lchk("t1_xfer", 1, i, '{ins: 16'h4A11 + 16'(i), pc: 24'h100 + 24'(2 * i), f: 0, pv: 0, pfx: 0});

      // FW=32 even and odd-halfword starts
      loga.delete();
      a_ordy = 1; a_fv = 1; a_fd = 32'h12345678; a_pc = 24'h200;
      step();
      a_fv = 0;
      repeat (3) step();
      chk("t2_count", loga.size(), 2);
      lchk("t2_lo", 0, 0, '{ins: 16'h5678, pc: 24'h200, f: 0, pv: 0, pfx: 0});
      lchk("t2_hi", 0, 1, '{ins: 16'h1234, pc: 24'h202, f: 0, pv: 0, pfx: 0});
      loga.delete();
      a_fv = 1; a_fd = 32'hAAAA5555; a_pc = 24'h302;
      step();
      a_fv = 0;
      repeat (2) step();
      chk("t2_odd_count", loga.size(), 1);
      lchk("t2_odd", 0, 0, '{ins: 16'hAAAA, pc: 24'h302, f: 0, pv: 0, pfx: 0});

      // prefix waits for its partner, then fuses
      loga.delete();
      a_fv = 1; a_fd = {16'h5F12, 16'h0000}; a_pc = 24'h502;
      step();
      a_fv = 0;
      for (int i = 0; i < 3; i++) begin
         chk("t3_wait_valid", a_ov, 0);
         step();
      end
      a_fv = 1; a_fd = {16'h4A05, 16'h0000}; a_pc = 24'h506;
      step();
      a_fv = 0;
      chk("t3_fused_valid", a_ov, 1);
      chk("t3_fused_pv", a_opv, 1);
      step();
      chk("t3_empty_valid", a_ov, 0);
      chk("t3_empty_ready", a_rdy, 1);
      chk("t3_count", loga.size(), 1);
      lchk("t3_fused", 0, 0, '{ins: 16'h4A05, pc: 24'h506, f: 0, pv: 1, pfx: 16'h5F12});

      // faulted partner blocks fusion
      loga.delete();
      a_fv = 1; a_fd = {16'h5F12, 16'h0000}; a_pc = 24'h602; a_ff = 0;
      step();
      a_fd = {16'h4A05, 16'h0000}; a_pc = 24'h606; a_ff = 1;
      step();
      a_fv = 0; a_ff = 0;
      repeat (3) step();
      chk("t4_count", loga.size(), 2);
      lchk("t4_pfx_alone", 0, 0, '{ins: 16'h5F12, pc: 24'h602, f: 0, pv: 0, pfx: 0});
      lchk("t4_faulted", 0, 1, '{ins: 16'h4A05, pc: 24'h606, f: 1, pv: 0, pfx: 0});

      // FUSE=0 treats the prefix as ordinary
      logb.delete();
      b_fv = 1; b_fd = 16'h5F12; b_pc = 24'h700;
      step();
      chk("t4b_no_wait", b_ov, 1);
      b_fd = 16'h4A05; b_pc = 24'h702;
      step();
      b_fv = 0;
      repeat (3) step();
      chk("t4b_count", logb.size(), 2);
      lchk("t4b_first", 1, 0, '{ins: 16'h5F12, pc: 24'h700, f: 0, pv: 0, pfx: 0});
      lchk("t4b_second", 1, 1, '{ins: 16'h4A05, pc: 24'h702, f: 0, pv: 0, pfx: 0});

      // flush with a simultaneous push
      b_ordy = 0;
      for (int i = 0; i < 3; i++) begin
         b_fv = 1; b_fd = 16'h4A31 + 16'(i); b_pc = 24'h300 + 24'(2 * i);
         step();
      end
      b_fd = 16'h1111; b_pc = 24'h306; b_fl = 1;
      step();
      b_fl = 0; b_fv = 0;
      chk("t5_flush_valid", b_ov, 0);
      chk("t5_flush_ready", b_rdy, 1);
      b_fv = 1; b_fd = 16'h4A40; b_pc = 24'h400;
      step();
      b_fv = 0;
      chk("t5_post_valid", b_ov, 1);
      chk("t5_post_ins", b_oins, 16'h4A40);
      chk("t5_post_pc", b_opc, 24'h400);
      b_ordy = 1;
      repeat (2) step();

      // sustained streaming across pointer wrap
      loga.delete();
      a_ordy = 1; pcw = 24'h800; pushed = 0;
      for (int c = 0; c < 20; c++) begin
         a_fv = 1; a_fd = {16'h4A80 + 16'(c), 16'h4A00 + 16'(c)}; a_pc = pcw;
         acc = a_rdy;
         step();
         if (acc) begin
            pcw = pcw + 24'd4;
            pushed = pushed + 2;
         end
      end
      a_fv = 0;
      repeat (8) step();
      chk("t6_count", loga.size(), pushed);
      for (int i = 0; i < loga.size(); i++)
         chk("t6_pc_seq", loga[i].pc, 24'h800 + 24'(2 * i));

      // randomized traffic on both instances
      for (int i = 0; i < 2000; i++) begin
         reset = (i == 1000);
         a_fv = $urandom_range(3) != 0;
         a_fd = {rnd16(), rnd16()};
         a_pc = 24'($urandom) & 24'hFFFFFE;
         a_ff = $urandom_range(7) == 0;
         a_fl = $urandom_range(15) == 0;
         a_ordy = $urandom_range(3) != 0;
         b_fv = $urandom_range(3) != 0;
         b_fd = rnd16();
         b_pc = 24'($urandom) & 24'hFFFFFE;
         b_ff = $urandom_range(7) == 0;
         b_fl = $urandom_range(15) == 0;
         b_ordy = $urandom_range(3) != 0;
         step();
      end
      reset = 0;
      a_fv = 0; a_fl = 0; b_fv = 0; b_fl = 0;
      repeat (2) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
